// File: rtl/countdown_timer_pkg.sv
// Shared constants and types for the BCD countdown timer.
// Imported by the digit cell and the timer top.
package countdown_timer_pkg;

    localparam int BCD_DIGIT_W  = 4;
    localparam int MAX_SEC_TENS = 5;
    localparam int MAX_DIGIT    = 9;

    // One operation is applied per cycle; the decoder resolves priority.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_ADD_MIN,
        OP_DEC
    } op_e;

    // A seconds-ones digit promoted to seconds-tens cannot exceed 5.
    function automatic logic [BCD_DIGIT_W-1:0] clamp_sec_tens(
        input logic [BCD_DIGIT_W-1:0] d
    );
        if (d > BCD_DIGIT_W'(MAX_SEC_TENS)) begin
            return BCD_DIGIT_W'(MAX_SEC_TENS);
        end
        return d;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD digit of modulus 6 or 10 with parallel load, borrow and carry chaining.
// Priority inside the cell: clr > load_en > borrow_in > carry_in.
module bcd_digit
    import countdown_timer_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGIT_W = BCD_DIGIT_W
) (
    input  logic               clock,
    input  logic               clr,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               borrow_in,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] value,
    output logic               borrow_out,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

    logic at_zero;
    logic at_top;

    assign at_zero    = (value == '0);
    assign at_top     = (value == TOP);
    assign borrow_out = borrow_in & at_zero;
    assign carry_out  = carry_in & at_top;

    // NOTE: state registers use non-blocking assignments so every digit in the
    // chain samples its neighbours' pre-edge values, whatever the block order.
    always_ff @(posedge clock) begin
        if (clr) begin
            value <= '0;
        end else if (load_en) begin
            value <= load_val;
        end else if (borrow_in) begin
            value <= at_zero ? TOP : value - DIGIT_W'(1);
        end else if (carry_in) begin
            value <= at_top ? '0 : value + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Keypad-loaded BCD countdown timer (m..m:ss) with add-minute and done pulse.
// Digit index 0 = seconds ones, 1 = seconds tens, 2.. = minutes, LSD first.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int MIN_DIGITS = 1,
    parameter int DIGIT_W    = BCD_DIGIT_W
) (
    input  logic                          clock,
    input  logic                          clr,
    input  logic [DIGIT_W-1:0]            data,
    input  logic                          load,
    input  logic                          tick,
    input  logic                          enable,
    input  logic                          add_min,
    output logic [DIGIT_W-1:0]            sec_ones,
    output logic [DIGIT_W-1:0]            sec_tens,
    output logic [DIGIT_W*MIN_DIGITS-1:0] mins,
    output logic                          zero,
    output logic                          done
);

    localparam int NUM_DIGITS = 2 + MIN_DIGITS;

    op_e                      op;
    logic                     data_ok;
    logic                     load_en;
    logic                     dec;
    logic                     inc;
    logic                     mins_sat;
    logic                     one_left;
    logic [DIGIT_W-1:0]       digit_q  [NUM_DIGITS];
    logic [DIGIT_W-1:0]       load_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]    nonzero;
    logic [NUM_DIGITS-1:0]    borrow_in;
    logic [NUM_DIGITS-1:0]    borrow_out;
    logic [NUM_DIGITS-1:0]    carry_in;
    logic [NUM_DIGITS-1:0]    carry_out;
    logic [2:0]               unused_chain_ends;

    assign data_ok = (data <= DIGIT_W'(MAX_DIGIT));
    assign zero    = ~|nonzero;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        op = OP_IDLE;
        if (load) begin
            op = OP_LOAD;
        end else if (add_min) begin
            op = OP_ADD_MIN;
        end else if (tick && enable && !zero) begin
            op = OP_DEC;
        end
    end

    // An out-of-range keypad digit still wins priority, it just changes nothing.
    assign load_en = (op == OP_LOAD) && data_ok;
    assign dec     = (op == OP_DEC);
    assign inc     = (op == OP_ADD_MIN) && !mins_sat;

    always_comb begin
        mins_sat = 1'b1;
        for (int i = 2; i < NUM_DIGITS; i++) begin
            if (digit_q[i] != DIGIT_W'(MAX_DIGIT)) begin
                mins_sat = 1'b0;
            end
        end
    end

    assign one_left = (digit_q[0] == DIGIT_W'(1)) && ~|nonzero[NUM_DIGITS-1:1];

    always_comb begin
        load_val[0] = data;
        load_val[1] = clamp_sec_tens(digit_q[0]);
        for (int i = 2; i < NUM_DIGITS; i++) begin
            load_val[i] = digit_q[i-1];
        end
    end

    // Borrows ripple upward from seconds ones; carries enter at the minutes LSD.
    assign borrow_in = {borrow_out[NUM_DIGITS-2:0], dec};

    always_comb begin
        carry_in    = {carry_out[NUM_DIGITS-2:0], 1'b0};
        carry_in[2] = inc;
    end

    assign unused_chain_ends = {carry_out[1], carry_out[NUM_DIGITS-1], borrow_out[NUM_DIGITS-1]};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int MOD = (i == 1) ? MAX_SEC_TENS + 1 : MAX_DIGIT + 1;

        bcd_digit #(
            .MODULUS (MOD),
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clock      (clock),
            .clr        (clr),
            .load_en    (load_en),
            .load_val   (load_val[i]),
            .borrow_in  (borrow_in[i]),
            .carry_in   (carry_in[i]),
            .value      (digit_q[i]),
            .borrow_out (borrow_out[i]),
            .carry_out  (carry_out[i])
        );

        assign nonzero[i] = |digit_q[i];
    end

    assign sec_ones = digit_q[0];
    assign sec_tens = digit_q[1];

    for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_mins
        assign mins[i*DIGIT_W +: DIGIT_W] = digit_q[i+2];
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            done <= 1'b0;
        end else begin
            done <= dec && one_left;
        end
    end

endmodule
